multi_tick_divider: RTL and testbench

//  Parametrised multi-channel clock-enable generator. Each channel divides clk by a

---
 rtl/tick_pkg.sv | 16 +
 rtl/tick_channel.sv | 107 ++++++++++
 rtl/multi_tick_divider.sv | 48 ++++
 tb/tb_multi_tick_divider.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/tick_pkg.sv
// Shared constants and helpers for the multi-channel tick divider.
// Defaults target a 50 MHz board clock giving a 2 Hz tick.
package tick_pkg;

  localparam int DEF_CNT_W = 26;
  localparam int DEF_DIV   = 25000000;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int ch_w(input int n);
    if (n <= 1) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One divider channel: period counter, active/pending divisor, tick and square wave.
// Divisor updates land only on a period boundary, so tick/wave never glitch.
module tick_channel
  import tick_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             restart,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             tick,
  output logic             wave,
  output logic             pending
);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] div_act_reg, div_act_next;
  logic [CNT_W-1:0] div_pend_reg, div_pend_next;
  logic             pend_reg, pend_next;
  logic             tick_reg, tick_next;
  logic             wave_reg, wave_next;

  logic             div_zero;
  logic             tc;
  logic [CNT_W-1:0] boundary_div;

  assign div_zero = (div_act_reg == '0);
  // >= rather than == so a transient cnt beyond a freshly shrunk divisor ends the period.
  assign tc       = !div_zero && (cnt_reg >= (div_act_reg - CNT_W'(1)));

  // Divisor that governs the next period when a boundary happens this edge.
  always_comb begin
    boundary_div = div_act_reg;
    if (wr) begin
      boundary_div = wr_div;
    end else if (pend_reg) begin
      boundary_div = div_pend_reg;
    end
  end

  always_comb begin
    cnt_next      = cnt_reg;
    div_act_next  = div_act_reg;
    div_pend_next = div_pend_reg;
    pend_next     = pend_reg;
    tick_next     = 1'b0;
    wave_next     = wave_reg;

    if (restart) begin
      cnt_next     = '0;
      wave_next    = 1'b0;
      div_act_next = boundary_div;
      pend_next    = 1'b0;
    end else if (!en) begin
      cnt_next  = '0;
      wave_next = 1'b0;
      if (wr) begin
        div_act_next = wr_div;
        pend_next    = 1'b0;
      end
    end else if (div_zero) begin
      // An idle channel has no period in flight, so every edge is a boundary.
      cnt_next     = '0;
      div_act_next = boundary_div;
      pend_next    = 1'b0;
    end else if (tc) begin
      cnt_next     = '0;
      tick_next    = 1'b1;
      wave_next    = ~wave_reg;
      div_act_next = boundary_div;
      pend_next    = 1'b0;
    end else begin
      cnt_next = cnt_reg + CNT_W'(1);
      if (wr) begin
        div_pend_next = wr_div;
        pend_next     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg      <= '0;
      div_act_reg  <= CNT_W'(DEFAULT_DIV);
      div_pend_reg <= '0;
      pend_reg     <= 1'b0;
      tick_reg     <= 1'b0;
      wave_reg     <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      div_act_reg  <= div_act_next;
      div_pend_reg <= div_pend_next;
      pend_reg     <= pend_next;
      tick_reg     <= tick_next;
      wave_reg     <= wave_next;
    end
  end

  assign tick    = tick_reg;
  assign wave    = wave_reg;
  assign pending = pend_reg;

endmodule

// File: rtl/multi_tick_divider.sv
// Multi-channel clock-enable generator: decodes divisor writes and fans out
// one tick_channel per channel.
module multi_tick_divider
  import tick_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEFAULT_DIV = DEF_DIV,
  localparam int CH_W       = ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync_restart,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] wave,
  output logic [NUM_CH-1:0] pending
);

  logic [NUM_CH-1:0] wr_dec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi = gi + 1) begin : g_ch
      // Only indices below NUM_CH exist, so an out-of-range cfg_ch matches nothing.
      assign wr_dec[gi] = cfg_we && (cfg_ch == CH_W'(gi));

      tick_channel #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
        .clk     (clk),
        .reset   (reset),
        .en      (en[gi]),
        .restart (sync_restart),
        .wr      (wr_dec[gi]),
        .wr_div  (cfg_div),
        .tick    (tick[gi]),
        .wave    (wave[gi]),
        .pending (pending[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_multi_tick_divider.sv
// Self-checking bench for multi_tick_divider: 3 channels, 8-bit counters, reset divisor 5.
module tb_multi_tick_divider;

  logic       clk;
  logic       reset;
  logic [2:0] en;
  logic       sync_restart;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic [2:0] tick;
  logic [2:0] wave;
  logic [2:0] pending;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] t;
    logic [2:0] w;
    logic [2:0] p;
  } exp_t;

  typedef struct {
    logic [2:0] en;
    logic       rs;
    logic       we;
    logic [1:0] ch;
    logic [7:0] dv;
    logic [2:0] t;
    logic [2:0] w;
    logic [2:0] p;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[$];

  multi_tick_divider #(
    .NUM_CH      (3),
    .CNT_W       (8),
    .DEFAULT_DIV (5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .sync_restart (sync_restart),
    .cfg_we       (cfg_we),
    .cfg_ch       (cfg_ch),
    .cfg_div      (cfg_div),
    .tick         (tick),
    .wave         (wave),
    .pending      (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // One clock transaction: drive, queue the expectation, clock, compare.
  task automatic step(input string tag, input logic [2:0] e, input logic rs, input logic we,
                      input logic [1:0] ch, input logic [7:0] dv,
                      input logic [2:0] t, input logic [2:0] w, input logic [2:0] p);
    exp_t got;
    en           = e;
    sync_restart = rs;
    cfg_we       = we;
    cfg_ch       = ch;
    cfg_div      = dv;
    exp_q.push_back('{t: t, w: w, p: p});
    @(posedge clk);
    #1;
    cfg_we       = 1'b0;
    sync_restart = 1'b0;
    got = exp_q.pop_front();
    chk({tag, " tick"}, tick, got.t);
    chk({tag, " wave"}, wave, got.w);
    chk({tag, " pending"}, pending, got.p);
    $display("step %s en=%b rs=%b we=%b ch=%0d div=%0d tick=%b wave=%b pending=%b",
             tag, e, rs, we, ch, dv, tick, wave, pending);
  endtask

  task automatic add(input logic [2:0] e, input logic rs, input logic we, input logic [1:0] ch,
                     input logic [7:0] dv, input logic [2:0] t, input logic [2:0] w,
                     input logic [2:0] p);
    tbl.push_back('{en: e, rs: rs, we: we, ch: ch, dv: dv, t: t, w: w, p: p});
  endtask

  initial begin
    // Period / edge-divisor table, applied right after the mid-run reset.
    add(3'b000, 0, 1, 2'd1, 8'd4, 3'b000, 3'b000, 3'b000);
    add(3'b010, 0, 0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000);
    add(3'b010, 0, 0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000);
    add(3'b010, 0, 0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000);
    add(3'b010, 0, 0, 2'd0, 8'd0, 3'b010, 3'b010, 3'b000);
    add(3'b010, 0, 0, 2'd0, 8'd0, 3'b000, 3'b010, 3'b000);
    add(3'b010, 0, 0, 2'd0, 8'd0, 3'b000, 3'b010, 3'b000);
    add(3'b010, 0, 0, 2'd0, 8'd0, 3'b000, 3'b010, 3'b000);
    add(3'b010, 0, 0, 2'd0, 8'd0, 3'b010, 3'b000, 3'b000);
    add(3'b010, 0, 0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000);
    add(3'b010, 0, 0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000);
    add(3'b000, 0, 1, 2'd1, 8'd1, 3'b000, 3'b000, 3'b000);
    add(3'b010, 0, 0, 2'd0, 8'd0, 3'b010, 3'b010, 3'b000);
    add(3'b010, 0, 0, 2'd0, 8'd0, 3'b010, 3'b000, 3'b000);
    add(3'b010, 0, 0, 2'd0, 8'd0, 3'b010, 3'b010, 3'b000);
    add(3'b000, 0, 1, 2'd1, 8'd0, 3'b000, 3'b000, 3'b000);
    add(3'b010, 0, 0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000);
    add(3'b010, 0, 0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000);
    add(3'b010, 0, 0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000);

    reset = 1'b1; en = '0; sync_restart = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset tick", tick, 3'b000);
    chk("reset wave", wave, 3'b000);
    chk("reset pending", pending, 3'b000);
    reset = 1'b0;

    // Reset divisor 5: first tick on the 5th enabled edge.
    for (int k = 1; k <= 7; k++) begin
      step($sformatf("div5 k%0d", k), 3'b001, 0, 0, 2'd0, 8'd0,
           (k == 5) ? 3'b001 : 3'b000, (k >= 5) ? 3'b001 : 3'b000, 3'b000);
    end
    #2;
    reset = 1'b1;
    #1;
    chk("async reset tick", tick, 3'b000);
    chk("async reset wave", wave, 3'b000);
    chk("async reset pending", pending, 3'b000);
    $display("step async_reset tick=%b wave=%b pending=%b", tick, wave, pending);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("tbl%0d", i), tbl[i].en, tbl[i].rs, tbl[i].we, tbl[i].ch, tbl[i].dv,
           tbl[i].t, tbl[i].w, tbl[i].p);
    end

    // Runtime change: 10 running, 7 then 3 written mid-period, then 2 written on a TC edge.
    step("ch2 div10", 3'b000, 0, 1, 2'd2, 8'd10, 3'b000, 3'b000, 3'b000);
    for (int k = 1; k <= 24; k++) begin
      logic       we_k;
      logic [7:0] dv_k;
      logic       t2, w2, p2;
      we_k = (k == 3) || (k == 5) || (k == 19);
      dv_k = (k == 3) ? 8'd7 : (k == 5) ? 8'd3 : 8'd2;
      t2   = (k == 10) || (k == 13) || (k == 16) || (k == 19) || (k == 21) || (k == 23);
      if (k < 10)      w2 = 1'b0;
      else if (k < 19) w2 = (((k - 10) / 3) % 2) == 0;
      else             w2 = (((k - 19) / 2) % 2) == 1;
      p2   = (k >= 3) && (k <= 9);
      step($sformatf("chg k%0d", k), 3'b100, 0, we_k, 2'd2, dv_k,
           {t2, 2'b00}, {w2, 2'b00}, {p2, 2'b00});
    end

    // Restart aligns ch0/ch2 and applies ch2's pending divisor.
    step("rs wr0", 3'b000, 0, 1, 2'd0, 8'd6, 3'b000, 3'b000, 3'b000);
    step("rs wr2", 3'b000, 0, 1, 2'd2, 8'd9, 3'b000, 3'b000, 3'b000);
    step("rs c1", 3'b001, 0, 0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000);
    step("rs c2", 3'b001, 0, 0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000);
    step("rs pend", 3'b101, 0, 1, 2'd2, 8'd6, 3'b000, 3'b000, 3'b100);
    step("rs hold", 3'b101, 0, 0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b100);
    step("rs pulse", 3'b101, 1, 0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000);
    for (int k = 1; k <= 7; k++) begin
      step($sformatf("rs k%0d", k), 3'b101, 0, 0, 2'd0, 8'd0,
           (k == 6) ? 3'b101 : 3'b000, (k >= 6) ? 3'b101 : 3'b000, 3'b000);
    end

    // Out-of-range channel writes must not touch any channel.
    step("bad idle", 3'b000, 0, 1, 2'd3, 8'd1, 3'b000, 3'b000, 3'b000);
    for (int k = 1; k <= 6; k++) begin
      step($sformatf("bad k%0d", k), 3'b111, 0, (k == 2), 2'd3, 8'd1,
           (k == 6) ? 3'b101 : 3'b000, (k == 6) ? 3'b101 : 3'b000, 3'b000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
